fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch sequencer for the IFU: owns the fetch PC register, issues one instruction-bus request at a time, and hands fetched instructions to decode with valid/ready. Arbitrates next-PC sources with priority CSR flush > branch redirect > sequential PC+4, using the existing `pcnxt` combinational block. Sits between the instruction bus and the decode stage. Guarantees that no stale instruction is delivered after a redirect or flush.

## Interface
- `RESET_PC`, 64'h8000_0000, first fetch address after reset
- `clk`  in  1  clock; one clock domain; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `ireq_valid`  out  1  fetch request valid
- `ireq_addr`  out  64  fetch address; equals `pc_q`
- `ireq_ready`  in  1  bus accepts request this cycle
- `iresp_valid`  in  1  response data valid; at most one per accepted request
- `iresp_data`  in  32  fetched instruction
- `redirect_valid`  in  1  branch/jump redirect, one-cycle pulse
- `redirect_target`  in  64  redirect PC
- `flush`  in  1  CSR flush (trap/mret), one-cycle pulse
- `csr_new_pc`  in  64  flush PC
- `inst_valid`  out  1  instruction valid to decode
- `inst_ready`  in  1  decode accepts
- `inst_pc`  out  64  PC of `inst_data`
- `inst_data`  out  32  instruction word

## Operation
- States: IDLE, REQ, WAIT, HOLD.
- Event = `flush | redirect_valid` in the current cycle. Event target: `csr_new_pc` when `flush`, else `redirect_target`.
- Pending register `pend_v` / `pend_pc`:
  - Captures any event not consumed in the same cycle.
  - A newer event overwrites a pending redirect.
  - A pending flush is overwritten only by a newer flush.
- Effective redirect: the current-cycle event if present, else the pending one. It drives `pcnxt` (`pc_in`=`pc_q`, `flush`/`redirect_valid` selected accordingly) to form `pc_nxt`.
- IDLE: outputs low; go to REQ next cycle.
- REQ:
  - `ireq_valid`=1, `ireq_addr`=`pc_q`. Address is held stable until `ireq_ready`.
  - An event here only sets pending.
  - On `ireq_ready`, go to WAIT.
- WAIT:
  - On `iresp_valid` with an effective redirect: drop the data, `pc_q`←`pc_nxt`, clear pending, go to REQ.
  - On `iresp_valid` without one: latch `inst_data`←`iresp_data`, `inst_pc`←`pc_q`, go to HOLD.
  - An event without `iresp_valid` sets pending.
- HOLD:
  - `inst_valid` = `!flush && !redirect_valid`, i.e. masked combinationally by a same-cycle event.
  - Event: instruction discarded regardless of `inst_ready`, `pc_q`←target, go to REQ.
  - `inst_ready` and no event: `pc_q`←`pc_q+4` (64-bit wrap, no overflow flag), go to REQ.
  - Otherwise hold `inst_*` stable.
- Pending is empty in HOLD by construction: it is consumed in WAIT.
- Reset mid-operation:
  - Returns to IDLE and clears pending.
  - Any `iresp_valid` arriving after reset while in IDLE or REQ is ignored; the bus is responsible for no late response.

## Timing
- Reset values:
  - `ireq_valid`=0, `inst_valid`=0, `ireq_addr`=`RESET_PC`, `inst_pc`=0, `inst_data`=0.
  - State IDLE, `pend_v`=0, `pc_q`=`RESET_PC`.
- First `ireq_valid` occurs in the 2nd cycle after reset deasserts.
- Zero-wait bus (ready in the REQ cycle, response the cycle after): REQ→WAIT→HOLD, so `inst_valid` is 2 cycles after `ireq_valid` rises. Steady state is 1 instruction per 3 cycles with `inst_ready`=1.
- Event in HOLD: `ireq_valid` with the new address in the next cycle.
- Event in REQ/WAIT: extra latency equals the remaining bus latency plus 1 cycle.
- Flush and redirect in the same cycle: flush wins, redirect is lost.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum (IDLE, REQ, WAIT, HOLD)
  - `RESET_PC_DEFAULT` constant
  - `addr_t` (64-bit) and `inst_t` (32-bit) typedefs
- One sub-module instance: `pcnxt` for next-PC selection; no other hierarchy.
- Estimated size: about 150–200 lines.

## Test plan
- Reset, then zero-wait bus with `iresp_data` = 32'h0000_0013, `inst_ready`=1. Expected:
  - `ireq_addr` sequence 8000_0000, 8000_0004, 8000_0008.
  - `inst_pc` matches that sequence; one `inst_valid` per 3 cycles.
- `redirect_valid`=1 with target 8000_1000 while in WAIT, response 3 cycles later. Expected: that response is dropped (no `inst_valid`); next `ireq_addr` = 8000_1000.
- `flush`=1 (`csr_new_pc`=8000_0100) and `redirect_valid`=1 (target 8000_2000) in the same HOLD cycle with `inst_ready`=1. Expected: no handshake; next `ireq_addr` = 8000_0100.
- `inst_ready`=0 for 5 cycles in HOLD. Expected: `inst_valid`, `inst_pc`, `inst_data` stable and no `ireq_valid`; the request for PC+4 follows one cycle after the `inst_ready` handshake.
- `ireq_ready` held low 4 cycles while redirect to 8000_3000 pulses in REQ. Expected:
  - `ireq_addr` stays at the old PC.
  - The response is dropped.
  - The following request goes to 8000_3000.
- Reset asserted in WAIT with pending set. Expected: all outputs at reset values; fetch restarts at `RESET_PC`; pending cleared.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   typedef logic [63:0] addr_t;
   typedef logic [31:0] inst_t;

   localparam addr_t RESET_PC_DEFAULT = 64'h8000_0000;
   localparam addr_t INST_BYTES       = 64'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/pcnxt.sv
// Next-PC selection: CSR flush beats branch redirect beats sequential PC+4.
module pcnxt
   import fetch_pkg::*;
(
   input  addr_t pc_in,
   input  logic  flush,
   input  addr_t csr_new_pc,
   input  logic  redirect_valid,
   input  addr_t redirect_target,
   output addr_t pc_nxt
);

   // Priority mux; the sequential path wraps at 64 bits.
   always_comb begin
      pc_nxt = pc_in + INST_BYTES;
      if (flush) begin
         pc_nxt = csr_new_pc;
      end else if (redirect_valid) begin
         pc_nxt = redirect_target;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one bus request at a
// time and presents each fetched instruction to decode until it is accepted.
// Redirects and flushes that arrive while a request is outstanding are parked
// in a pending register so the in-flight response can be dropped.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter addr_t RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        ireq_ready,
   input  logic        iresp_valid,
   input  logic [31:0] iresp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_target,
   input  logic        flush,
   input  logic [63:0] csr_new_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [63:0] inst_pc,
   output logic [31:0] inst_data
);

   fetch_state_t state_q, state_d;
   addr_t        pc_q, pc_d;
   addr_t        pc_nxt;
   logic         pend_v_q, pend_flush_q;
   addr_t        pend_pc_q;
   addr_t        inst_pc_q;
   inst_t        inst_data_q;

   logic  ev_now;
   addr_t ev_pc;
   logic  eff_v;
   logic  sel_flush, sel_redirect;
   addr_t sel_pc;
   logic  consume;
   logic  latch_inst;

   // Effective redirect: a same-cycle event takes precedence over a parked one.
   always_comb begin
      ev_now       = flush | redirect_valid;
      ev_pc        = flush ? csr_new_pc : redirect_target;
      eff_v        = ev_now | pend_v_q;
      sel_flush    = ev_now ? flush : (pend_v_q & pend_flush_q);
      sel_redirect = ev_now ? (redirect_valid & ~flush) : (pend_v_q & ~pend_flush_q);
      sel_pc       = ev_now ? ev_pc : pend_pc_q;
   end

   pcnxt u_pcnxt (
      .pc_in           (pc_q),
      .flush           (sel_flush),
      .csr_new_pc      (sel_pc),
      .redirect_valid  (sel_redirect),
      .redirect_target (sel_pc),
      .pc_nxt          (pc_nxt)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, PC update and handshake outputs.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      consume    = 1'b0;
      latch_inst = 1'b0;
      ireq_valid = 1'b0;
      inst_valid = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = REQ;
         end
         REQ: begin
            ireq_valid = 1'b1;
            if (ireq_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (iresp_valid) begin
               consume = 1'b1;
               if (eff_v) begin
                  pc_d    = pc_nxt;
                  state_d = REQ;
               end else begin
                  latch_inst = 1'b1;
                  state_d    = HOLD;
               end
            end
         end
         HOLD: begin
            inst_valid = ~ev_now;
            consume    = 1'b1;
            if (ev_now || inst_ready) begin
               pc_d    = pc_nxt;
               state_d = REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Pending event: a pending flush may only be replaced by a newer flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_v_q     <= 1'b0;
         pend_flush_q <= 1'b0;
         pend_pc_q    <= '0;
      end else if (consume) begin
         pend_v_q     <= 1'b0;
         pend_flush_q <= 1'b0;
      end else if (ev_now && !(pend_v_q && pend_flush_q && !flush)) begin
         pend_v_q     <= 1'b1;
         pend_flush_q <= flush;
         pend_pc_q    <= ev_pc;
      end
   end

   // Fetch PC and the instruction holding register for decode.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         inst_pc_q   <= '0;
         inst_data_q <= '0;
      end else begin
         pc_q <= pc_d;
         if (latch_inst) begin
            inst_pc_q   <= pc_q;
            inst_data_q <= iresp_data;
         end
      end
   end

   assign ireq_addr = pc_q;
   assign inst_pc   = inst_pc_q;
   assign inst_data = inst_data_q;

endmodule
